uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin, message-locked arbiter that shares one byte-wide UART transmitter between NUM_REQ requesters. It sits between the message sources and the UART transmit core. A requester that wins arbitration keeps the transmitter until it sends the last byte of its message. The block paces each byte on the transmitter's busy handshake and inserts a configurable idle gap between messages.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- GAP_CYCLES, 434: idle cycles between messages; 0 means no gap
- START_TIMEOUT, 8: cycles to wait for tx_busy to rise after tx_start
- HOLD_TIMEOUT, 65535: cycles the owner may stall mid-message before the message is aborted
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  requester i has a byte pending
- req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i]
- req_last  in  NUM_REQ  pending byte is the last byte of the message
- req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i captured
- grant  out  NUM_REQ  one-hot owner of the transmitter; all zero when unowned
- active  out  1  high whenever state is not IDLE
- tx_start  out  1  one-cycle pulse to the transmitter: send tx_data
- tx_data  out  8  byte to transmit, held until the next capture
- tx_busy  in  1  transmitter is sending a frame
- err  out  1  one-cycle pulse on a start or hold timeout

## Operation
- Reset (asynchronous on rst_n low): state IDLE; all outputs 0; priority pointer ptr=0; all counters 0.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE
  - If |req: owner = first i with req[i]=1, searching ptr, ptr+1, ... modulo NUM_REQ.
  - grant <= onehot(owner); go to LOAD; hold counter cleared.
  - Otherwise stay in IDLE.
- LOAD
  - If req[owner]=1:
    - tx_data <= byte of owner
    - tx_start <= 1 and req_ack[owner] <= 1, both for exactly one cycle
    - last_q <= req_last[owner]
    - start counter cleared; go to WAIT_BUSY
  - If req[owner]=0: increment the hold counter. When it reaches HOLD_TIMEOUT: err pulse, then release.
- WAIT_BUSY
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise increment the start counter. When it reaches START_TIMEOUT: err pulse, then release (the message is abandoned).
- WAIT_DONE
  - On tx_busy=0: if last_q, release. Otherwise go to LOAD with the hold counter cleared.
- Release
  - grant <= 0; ptr <= (owner+1) mod NUM_REQ.
  - Go to GAP, or directly to IDLE if GAP_CYCLES=0.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests are ignored during the gap.
- Requests from non-owners are ignored while grant is nonzero. Their req_ack stays 0.
- Requester contract: hold req, data and last stable until req_ack is seen. The byte is captured on the edge that raises req_ack. The requester may present its next byte in the following cycle. A double capture is impossible because WAIT_BUSY lasts at least one cycle.
- A single-byte message (req_last=1 on the first byte) is legal.
- Exactly one ack is issued per byte, including a byte later abandoned by START_TIMEOUT.
- Counter widths are sized from the parameters. No counter wraps silently.

## Timing
- IDLE with req sampled at edge T: grant valid after T.
- In LOAD at edge T+1: tx_start, req_ack and tx_data valid in the cycle after T+1.
- First tx_start occurs 2 cycles after req is seen in IDLE.
- Next tx_start within a message: 2 cycles after tx_busy falls, provided the owner's req is already high.
- Message-to-message turnaround: 1 release edge + GAP_CYCLES + 2 cycles.
- tx_start is never asserted while tx_busy=1. req_ack and tx_start are always coincident.
- active falls one cycle after the GAP count expires. err is coincident with the release edge.

## Test plan
- Single requester: req[0]=1 with bytes 0x73, 0x61, last on 0x61, GAP_CYCLES=4, tx_busy model high 3 cycles after each start.
  - Required: two tx_start pulses carrying 0x73 then 0x61.
  - Required: req_ack[0] coincident with each tx_start; grant=0001 throughout the message.
  - Required: 4 idle cycles, then IDLE, with ptr=1.
- Simultaneous req=1111 out of reset, each requester sending a 1-byte message (req_last=1).
  - Required: grants in order 0,1,2,3.
  - Required: each requester acked exactly once; no overlap of tx_start with tx_busy.
- Requester 2 locked mid-message while req[1] is held high.
  - Required: req_ack[1]=0 until requester 2's last byte completes.
  - Required: requester 1 is then granted only if it is next from ptr=3 (wrap to 0, then 1).
- tx_busy tied 0, START_TIMEOUT=8.
  - Required: err pulses 8 cycles after tx_start; grant cleared; arbitration resumes after the gap.
- Owner drops req after the first byte, HOLD_TIMEOUT=16.
  - Required: err at the 16th stalled cycle; ptr advances; a waiting requester is granted next.
- rst_n low during WAIT_DONE.
  - Required: all outputs 0 immediately; state IDLE.
  - Required: ptr=0 after rst_n rises; no req_ack for the interrupted byte.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one byte-wide UART transmitter
// between NUM_REQ requesters, paced on tx_busy with an idle gap between messages.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned GAP_CYCLES    = 434,
    parameter int unsigned START_TIMEOUT = 8,
    parameter int unsigned HOLD_TIMEOUT  = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 active,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 err
);

    localparam int unsigned OWN_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W      = OWN_W + 1;
    localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned START_W    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int unsigned HOLD_W     = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam int unsigned GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned START_LAST = (START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0;
    localparam int unsigned HOLD_LAST  = (HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t              state;
    logic [OWN_W-1:0]    ptr;
    logic [OWN_W-1:0]    owner;
    logic                last_q;
    logic [GAP_W-1:0]    gap_cnt;
    logic [START_W-1:0]  start_cnt;
    logic [HOLD_W-1:0]   hold_cnt;

    logic [OWN_W-1:0]    winner;
    logic [OWN_W-1:0]    ptr_next;
    logic                hold_expire;
    logic                start_expire;
    logic                msg_done;
    logic                rel;

    // First pending requester searching ptr, ptr+1, ... modulo NUM_REQ
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic             found;
        winner = ptr;
        found  = 1'b0;
        sum    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            if (!found && req[OWN_W'(sum)]) begin
                winner = OWN_W'(sum);
                found  = 1'b1;
            end
        end
    end

    assign ptr_next     = (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + OWN_W'(1);
    assign hold_expire  = (state == LOAD) && !req[owner] && (hold_cnt == HOLD_W'(HOLD_LAST));
    assign start_expire = (state == WAIT_BUSY) && !tx_busy && (start_cnt == START_W'(START_LAST));
    assign msg_done     = (state == WAIT_DONE) && !tx_busy && last_q;
    assign rel          = hold_expire | start_expire | msg_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            last_q    <= 1'b0;
            gap_cnt   <= '0;
            start_cnt <= '0;
            hold_cnt  <= '0;
            grant     <= '0;
            req_ack   <= '0;
            active    <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            err       <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            req_ack  <= '0;
            err      <= 1'b0;
            if (rel) begin
                // Give up the transmitter and rotate priority past the owner
                grant   <= '0;
                ptr     <= ptr_next;
                err     <= hold_expire | start_expire;
                gap_cnt <= '0;
                if (GAP_CYCLES == 0) begin
                    state  <= IDLE;
                    active <= 1'b0;
                end else begin
                    state <= GAP;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (|req) begin
                            owner    <= winner;
                            grant    <= NUM_REQ'(1) << winner;
                            hold_cnt <= '0;
                            active   <= 1'b1;
                            state    <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (req[owner]) begin
                            tx_data   <= req_data[{owner, 3'b000} +: 8];
                            tx_start  <= 1'b1;
                            req_ack   <= NUM_REQ'(1) << owner;
                            last_q    <= req_last[owner];
                            start_cnt <= '0;
                            state     <= WAIT_BUSY;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    WAIT_BUSY: begin
                        if (tx_busy) begin
                            state <= WAIT_DONE;
                        end else begin
                            start_cnt <= start_cnt + START_W'(1);
                        end
                    end
                    WAIT_DONE: begin
                        // Last-byte completion is handled by the release path
                        if (!tx_busy) begin
                            hold_cnt <= '0;
                            state    <= LOAD;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_W'(GAP_LAST)) begin
                            active <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin vector table plus hand-written
// sequences for message locking, start/hold timeouts and mid-message reset.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic        active;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        err;

    int n_cmp = 0;
    int n_fail = 0;
    int ack_total = 0;
    int ack_cnt [4] = '{0, 0, 0, 0};
    int err_cnt = 0;

    logic model_en = 1'b1;
    int   busy_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .GAP_CYCLES   (4),
        .START_TIMEOUT(8),
        .HOLD_TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_data(req_data),
        .req_last(req_last),
        .req_ack (req_ack),
        .grant   (grant),
        .active  (active),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .err     (err)
    );

    // Transmitter model: busy for 3 cycles starting the edge after tx_start
    always @(posedge clk) begin
        if (model_en && tx_start) busy_cnt <= 3;
        else if (busy_cnt > 0)    busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = model_en && (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle invariants and ack/err bookkeeping
    always @(negedge clk) begin
        check("mon_overlap", 32'(tx_start & tx_busy), 32'd0);
        check("mon_ack", 32'(req_ack), tx_start ? 32'(grant) : 32'd0);
        check("mon_onehot", 32'($onehot0(grant)), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (req_ack[i]) begin
                ack_cnt[i]++;
                ack_total++;
            end
        end
        if (err) err_cnt++;
    end

    // sel: 0 tx_start, 1 err, 2 active low, 3 grant cleared
    task automatic wait_sig(input string name, input int sel, input int budget, output int cycles);
        logic hit;
        hit = 1'b0;
        cycles = 0;
        while (!hit && cycles < budget) begin
            @(negedge clk);
            cycles++;
            case (sel)
                0:       hit = tx_start;
                1:       hit = err;
                2:       hit = !active;
                3:       hit = (grant == 4'b0000);
                default: hit = 1'b1;
            endcase
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic run_msg(input logic [3:0] mask, input logic [3:0] exp_g, input logic [7:0] exp_d);
        int c;
        int acks0;
        int errs0;
        acks0 = ack_total;
        errs0 = err_cnt;
        req_data = 32'hA3A2A1A0;
        req_last = 4'hF;
        req = mask;
        wait_sig("rr_start", 0, 30, c);
        check("rr_grant", 32'(grant), 32'(exp_g));
        check("rr_data", 32'(tx_data), 32'(exp_d));
        req = '0;
        wait_sig("rr_idle", 2, 40, c);
        check("rr_one_ack", 32'(ack_total - acks0), 32'd1);
        check("rr_no_err", 32'(err_cnt - errs0), 32'd0);
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [3:0] exp_grant;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int c;
        int a1;
        int e0;

        vecs[0]  = '{4'b1111, 4'b0001, 8'hA0};
        vecs[1]  = '{4'b1111, 4'b0010, 8'hA1};
        vecs[2]  = '{4'b1111, 4'b0100, 8'hA2};
        vecs[3]  = '{4'b1111, 4'b1000, 8'hA3};
        vecs[4]  = '{4'b0001, 4'b0001, 8'hA0};
        vecs[5]  = '{4'b1001, 4'b1000, 8'hA3};
        vecs[6]  = '{4'b0110, 4'b0010, 8'hA1};
        vecs[7]  = '{4'b0011, 4'b0001, 8'hA0};
        vecs[8]  = '{4'b1100, 4'b0100, 8'hA2};
        vecs[9]  = '{4'b0111, 4'b0001, 8'hA0};
        vecs[10] = '{4'b0010, 4'b0010, 8'hA1};
        vecs[11] = '{4'b1110, 4'b0100, 8'hA2};
        vecs[12] = '{4'b0011, 4'b0001, 8'hA0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 32'(grant), 32'd0);

        // Round-robin table, starting with all four requesting out of reset
        for (int i = 0; i < 13; i++) begin
            run_msg(vecs[i].mask, vecs[i].exp_grant, vecs[i].exp_data);
        end

        // Single requester, two-byte message 0x73, 0x61
        req_data = 32'h0000_0073;
        req_last = 4'b0000;
        req = 4'b0001;
        @(negedge clk);
        check("b_grant", 32'(grant), 32'h1);
        check("b_no_start_yet", 32'(tx_start), 32'd0);
        check("b_active", 32'(active), 32'd1);
        @(negedge clk);
        check("b_start1", 32'(tx_start), 32'd1);
        check("b_data1", 32'(tx_data), 32'h73);
        check("b_ack1", 32'(req_ack), 32'h1);
        req_data = 32'h0000_0061;
        req_last = 4'b0001;
        wait_sig("b_start2_seen", 0, 20, c);
        check("b_start2_spacing", 32'(c), 32'd6);
        check("b_data2", 32'(tx_data), 32'h61);
        check("b_grant2", 32'(grant), 32'h1);
        req = '0;
        wait_sig("b_release_seen", 3, 20, c);
        check("b_release_delay", 32'(c), 32'd5);
        check("b_active_in_gap", 32'(active), 32'd1);
        wait_sig("b_gap_seen", 2, 20, c);
        check("b_gap_len", 32'(c), 32'd4);
        // ptr=1 so requester 1 wins over requester 0
        run_msg(4'b1111, 4'b0010, 8'hA1);

        // Requester 2 locked for three bytes while requester 1 waits
        a1 = ack_cnt[1];
        req_data = 32'hA3C0A1A0;
        req_last = 4'b0010;
        req = 4'b0110;
        wait_sig("d_start1", 0, 20, c);
        check("d_grant1", 32'(grant), 32'h4);
        check("d_data1", 32'(tx_data), 32'hC0);
        req_data[23:16] = 8'hC1;
        wait_sig("d_start2", 0, 20, c);
        check("d_grant2", 32'(grant), 32'h4);
        check("d_data2", 32'(tx_data), 32'hC1);
        req_data[23:16] = 8'hC2;
        req_last[2] = 1'b1;
        wait_sig("d_start3", 0, 20, c);
        check("d_data3", 32'(tx_data), 32'hC2);
        check("d_req1_not_acked", 32'(ack_cnt[1] - a1), 32'd0);
        req[2] = 1'b0;
        req[0] = 1'b1;
        req_last[0] = 1'b1;
        wait_sig("d_wrap_start", 0, 40, c);
        check("d_wrap_grant0", 32'(grant), 32'h1);
        check("d_wrap_data0", 32'(tx_data), 32'hA0);
        req[0] = 1'b0;
        wait_sig("d_next_start", 0, 40, c);
        check("d_grant1_after", 32'(grant), 32'h2);
        check("d_data1_after", 32'(tx_data), 32'hA1);
        req = '0;
        wait_sig("d_idle", 2, 40, c);

        // tx_busy held low: start timeout
        model_en = 1'b0;
        e0 = err_cnt;
        req_data = 32'hA3E5A1A0;
        req_last = 4'hF;
        req = 4'b0100;
        wait_sig("e_start", 0, 20, c);
        check("e_grant", 32'(grant), 32'h4);
        check("e_data", 32'(tx_data), 32'hE5);
        req = '0;
        wait_sig("e_err_seen", 1, 20, c);
        check("e_err_delay", 32'(c), 32'd8);
        check("e_grant_cleared", 32'(grant), 32'd0);
        check("e_active_in_gap", 32'(active), 32'd1);
        wait_sig("e_idle", 2, 20, c);
        check("e_one_err", 32'(err_cnt - e0), 32'd1);
        model_en = 1'b1;
        run_msg(4'b1111, 4'b1000, 8'hA3);

        // Owner stalls after its first byte: hold timeout
        e0 = err_cnt;
        req_data = 32'hA3A2A1B0;
        req_last = 4'b0010;
        req = 4'b0011;
        wait_sig("f_start", 0, 20, c);
        check("f_grant", 32'(grant), 32'h1);
        check("f_data", 32'(tx_data), 32'hB0);
        req[0] = 1'b0;
        wait_sig("f_err_seen", 1, 40, c);
        check("f_err_delay", 32'(c), 32'd21);
        check("f_grant_cleared", 32'(grant), 32'd0);
        wait_sig("f_next_start", 0, 40, c);
        check("f_next_grant", 32'(grant), 32'h2);
        check("f_next_data", 32'(tx_data), 32'hA1);
        req = '0;
        wait_sig("f_idle", 2, 40, c);
        check("f_one_err", 32'(err_cnt - e0), 32'd1);

        // Reset while the owner is in WAIT_DONE
        req_data = 32'hD0A2A1A0;
        req_last = 4'b0010;
        req = 4'b1010;
        wait_sig("g_start", 0, 20, c);
        check("g_grant", 32'(grant), 32'h8);
        check("g_data", 32'(tx_data), 32'hD0);
        repeat (2) @(negedge clk);
        a1 = ack_total;
        rst_n = 1'b0;
        #1;
        check("g_rst_grant", 32'(grant), 32'd0);
        check("g_rst_active", 32'(active), 32'd0);
        check("g_rst_start", 32'(tx_start), 32'd0);
        check("g_rst_ack", 32'(req_ack), 32'd0);
        check("g_rst_data", 32'(tx_data), 32'd0);
        check("g_rst_err", 32'(err), 32'd0);
        repeat (6) @(negedge clk);
        check("g_rst_hold_grant", 32'(grant), 32'd0);
        check("g_no_ack_in_rst", 32'(ack_total - a1), 32'd0);
        rst_n = 1'b1;
        wait_sig("g_after_start", 0, 20, c);
        check("g_after_grant", 32'(grant), 32'h2);
        check("g_after_data", 32'(tx_data), 32'hA1);
        req = '0;
        wait_sig("g_idle", 2, 40, c);
        check("g_single_ack", 32'(ack_total - a1), 32'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
